// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 16-bit multi-cycle proc: fetches words from a
// synchronous ROM, issues them with a one-cycle Run pulse and waits for Done.
module proc_sequencer #(
  parameter int AW       = 5,
  parameter int WAIT_MAX = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  input  logic          StepMode,
  input  logic [15:0]   RomData,
  input  logic          Done,
  output logic [AW-1:0] RomAddr,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Busy,
  output logic          Halted,
  output logic          IllegalOp,
  output logic [15:0]   InstrCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [WW-1:0] waitcnt;
  logic [15:0]   din_q;
  logic          halt_word;
  logic          wd_expire;
  logic          complete;

  assign halt_word = (RomData[15:13] == 3'b111);
  // Watchdog: unknown opcodes never raise Done, so force completion.
  assign wd_expire = !Done && (waitcnt == WW'(WAIT_MAX - 1));
  assign complete  = (state == S_WAIT) && (Done || wd_expire);

  assign RomAddr = pc;
  assign DIN     = (state == S_DECODE) ? RomData : din_q;
  assign Run     = (state == S_DECODE) && !halt_word;
  assign Busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_WAIT);
  assign Halted  = (state == S_HALT);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      pc         <= '0;
      waitcnt    <= '0;
      din_q      <= '0;
      IllegalOp  <= 1'b0;
      InstrCount <= '0;
    end else begin
      case (state)
        S_IDLE, S_PAUSE: if (Start && !Stop) state <= S_FETCH;
        S_FETCH:         state <= S_DECODE;
        S_DECODE: begin
          din_q <= RomData;
          if (halt_word) begin
            state <= S_HALT;
          end else begin
            waitcnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (complete) begin
            if (wd_expire) IllegalOp <= 1'b1;
            pc <= pc + AW'(1);
            if (InstrCount != 16'hFFFF) InstrCount <= InstrCount + 16'd1;
            state <= (Stop || StepMode) ? S_PAUSE : S_FETCH;
          end else begin
            waitcnt <= waitcnt + WW'(1);
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer with a behavioural ROM and a proc Done
// responder (mv/mvt finish in T1, add/sub in T3, anything else never finishes).
module tb_proc_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic        StepMode = 1'b0;
  logic [15:0] RomData = 16'h0;
  logic        Done;
  logic [4:0]  RomAddr;
  logic [15:0] DIN;
  logic        Run, Busy, Halted, IllegalOp;
  logic [15:0] InstrCount;

  proc_sequencer #(.AW(5), .WAIT_MAX(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .StepMode(StepMode),
    .RomData(RomData), .Done(Done), .RomAddr(RomAddr), .DIN(DIN), .Run(Run),
    .Busy(Busy), .Halted(Halted), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  logic [15:0] rom [32];
  always @(posedge Clock) RomData <= rom[RomAddr];

  // proc time-step model
  logic [1:0] tstep = 2'd0;
  logic [2:0] op = 3'd0;
  assign Done = ((tstep == 2'd1) && (op[2:1] == 2'b00)) ||
                ((tstep == 2'd3) && (op[2:1] == 2'b01));
  always @(posedge Clock) begin
    if (!Resetn) tstep <= 2'd0;
    else if (Run) begin tstep <= 2'd1; op <= DIN[15:13]; end
    else if (tstep != 2'd0) tstep <= (Done || tstep == 2'd3) ? 2'd0 : tstep + 2'd1;
  end

  int runs = 0, busycnt = 0;
  logic [4:0] addr_log [64];
  logic [15:0] last_run_din = 16'h0;
  always @(posedge Clock) begin
    if (Resetn && Run) begin
      if (runs < 64) addr_log[runs] <= RomAddr;
      last_run_din <= DIN;
      runs <= runs + 1;
    end
    if (Resetn && Busy) busycnt <= busycnt + 1;
  end

  int npass = 0, ntotal = 0;
  int r0, b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; StepMode = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !Halted; i++) @(negedge Clock);
  endtask

  initial begin
    // Test 1: mv r0,#5 then HALT
    for (int i = 0; i < 32; i++) rom[i] = 16'h0;
    rom[0] = 16'h1005; rom[1] = 16'hE000;
    do_reset();
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_addr", RomAddr, 0);
    chk("rst_din", DIN, 0);
    chk("rst_cnt", InstrCount, 0);
    chk("rst_ill", IllegalOp, 0);
    r0 = runs;
    Start = 1'b1;
    wait_halt(40);
    chk("t1_halted", Halted, 1);
    chk("t1_runs", runs - r0, 1);
    chk("t1_din", last_run_din, 16'h1005);
    chk("t1_pc", RomAddr, 1);
    chk("t1_cnt", InstrCount, 1);
    chk("t1_ill", IllegalOp, 0);
    Start = 1'b0; Stop = 1'b1;
    repeat (3) @(negedge Clock);
    Start = 1'b1; Stop = 1'b0;
    repeat (3) @(negedge Clock);
    chk("t1_halt_sticky", Halted, 1);
    chk("t1_halt_nobusy", Busy, 0);

    // Test 2: mv r1,#3; add r1,#2; HALT
    rom[0] = 16'h1203; rom[1] = 16'h5202; rom[2] = 16'hE000;
    do_reset();
    b0 = busycnt;
    Start = 1'b1;
    wait_halt(60);
    chk("t2_halted", Halted, 1);
    chk("t2_busy_cycles", busycnt - b0, 10);
    chk("t2_cnt", InstrCount, 2);
    chk("t2_pc", RomAddr, 2);
    chk("t2_ill", IllegalOp, 0);

    // Test 3: unsupported opcode forced complete by watchdog
    rom[0] = 16'h8000; rom[1] = 16'hE000;
    do_reset();
    b0 = busycnt;
    Start = 1'b1;
    wait_halt(60);
    chk("t3_halted", Halted, 1);
    chk("t3_busy_cycles", busycnt - b0, 7);
    chk("t3_ill", IllegalOp, 1);
    chk("t3_pc", RomAddr, 1);
    chk("t3_cnt", InstrCount, 1);

    // Test 4: single-step through three mv instructions
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003; rom[3] = 16'hE000;
    do_reset();
    chk("t4_ill_cleared", IllegalOp, 0);
    StepMode = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      r0 = runs;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (5) @(negedge Clock);
      chk($sformatf("t4_cnt%0d", s), InstrCount, s);
      chk($sformatf("t4_runs%0d", s), runs - r0, 1);
      chk($sformatf("t4_paused%0d", s), {Busy, Halted}, 2'b00);
    end
    chk("t4_pc", RomAddr, 3);

    // Test 5: free run over all-mv ROM, PC wraps 31 -> 0
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000;
    do_reset();
    r0 = runs;
    Start = 1'b1;
    for (int i = 0; i < 200 && InstrCount < 16'd33; i++) @(negedge Clock);
    chk("t5_cnt_reached", InstrCount >= 16'd33, 1);
    chk("t5_addr0", addr_log[r0], 0);
    chk("t5_addr31", addr_log[r0 + 31], 31);
    chk("t5_addr_wrap", addr_log[r0 + 32], 0);
    Stop = 1'b1;
    for (int i = 0; i < 20 && Busy; i++) @(negedge Clock);
    chk("t5_stop_idle", Busy, 0);
    b0 = InstrCount;
    repeat (4) @(negedge Clock);
    chk("t5_stop_hold", InstrCount, b0);
    chk("t5_stop_busy", Busy, 0);

    // Test 6: reset during add WAIT, then Start+Stop in IDLE
    rom[0] = 16'h5202; rom[1] = 16'hE000;
    do_reset();
    Start = 1'b1;
    for (int i = 0; i < 10 && !Run; i++) @(negedge Clock);
    chk("t6_run_seen", Run, 1);
    @(negedge Clock);
    chk("t6_in_wait", Busy, 1);
    Resetn = 1'b0; Start = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    chk("t6_rst_cnt", InstrCount, 0);
    chk("t6_rst_pc", RomAddr, 0);
    chk("t6_rst_busy", Busy, 0);
    b0 = busycnt;
    Start = 1'b1; Stop = 1'b1;
    repeat (5) @(negedge Clock);
    chk("t6_stop_wins", busycnt - b0, 0);
    Stop = 1'b0;
    @(negedge Clock);
    chk("t6_start_fetch", Busy, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
